cla_pipe_adder: RTL and testbench

//  Parametrised two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.

---
 rtl/cla_pkg.sv | 47 ++++
 rtl/cla_group4.sv | 19 +
 rtl/cla_pipe_adder.sv | 175 +++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: group size,
// the stage-1 payload carried between the two pipeline stages, and the
// 4-bit lookahead equations used both for group generate/propagate and
// for the in-group carries.
// Optional feature macro: CLA_SAT_EN (saturating result on signed overflow).
package cla_pkg;

    localparam int CLA_GRP   = 4;
    localparam int CLA_MAX_W = 64;
    localparam int CLA_MAX_G = CLA_MAX_W / CLA_GRP;

    // Sized for the widest legal adder; narrower instances leave the upper
    // bits at zero and they drop out in synthesis.
    typedef struct packed {
        logic [CLA_MAX_W-1:0] g;
        logic [CLA_MAX_W-1:0] p;
        logic [CLA_MAX_W-1:0] x;
        logic [CLA_MAX_G-1:0] gg;
        logic [CLA_MAX_G-1:0] gp;
        logic                 c0;
        logic                 a_msb;
        logic                 be_msb;
        logic                 sat;
    } cla_s1_t;

    function automatic logic [4:1] cla_carries(input logic [3:0] g,
                                               input logic [3:0] p,
                                               input logic       ci);
        logic [4:1] c;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    function automatic logic cla_grp_gg(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic cla_grp_gp(input logic [3:0] p);
        return &p;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit lookahead unit: from per-bit generate/propagate and
// the group carry-in, produces the carries into bits 1..4 of the group plus
// the group generate/propagate terms.
module cla_group4
    import cla_pkg::*;
(
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       cgrp,
    output logic [4:1] c,
    output logic       gg,
    output logic       gp
);

    assign c  = cla_carries(g, p, cgrp);
    assign gg = cla_grp_gg(g, p);
    assign gp = cla_grp_gp(p);

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready.
// Stage 1 registers per-bit G/P/X and per-group GG/GP; stage 2 resolves the
// group carries, forms the sum and flags, and holds them while stalled.
// Optional feature macro: CLA_SAT_EN adds the sat input; a saturate request
// on an overflowing beat clamps the sum to the signed extreme.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NGRP  = WIDTH / CLA_GRP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef CLA_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    if (WIDTH < CLA_GRP || WIDTH > CLA_MAX_W || (WIDTH % CLA_GRP) != 0
        || NGRP != WIDTH / CLA_GRP) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 in 4..64, NGRP derived");
    end

    logic             v1;
    logic             v2;
    logic             rdy1;
    logic             rdy2;
    logic [WIDTH-1:0] be;
    logic             c0_in;
    logic             sat_in;
    cla_s1_t          s1_d;
    cla_s1_t          s1_q;

    // Ready ripples back from the output; in_valid never feeds in_ready.
    assign rdy2      = !v2 || out_ready;
    assign rdy1      = !v1 || rdy2;
    assign in_ready  = rdy1;
    assign out_valid = v2;

    // Subtraction is a + ~b + 1, so cin is overridden when sub is set.
    assign be    = sub ? ~b : b;
    assign c0_in = sub | cin;

`ifdef CLA_SAT_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    // Stage-1 payload: per-bit terms, group terms and operand signs.
    always_comb begin
        s1_d               = '0;
        s1_d.g[WIDTH-1:0]  = a & be;
        s1_d.p[WIDTH-1:0]  = a | be;
        s1_d.x[WIDTH-1:0]  = a ^ be;
        for (int k = 0; k < NGRP; k++) begin
            s1_d.gg[k] = cla_grp_gg(s1_d.g[k*CLA_GRP +: CLA_GRP], s1_d.p[k*CLA_GRP +: CLA_GRP]);
            s1_d.gp[k] = cla_grp_gp(s1_d.p[k*CLA_GRP +: CLA_GRP]);
        end
        s1_d.c0     = c0_in;
        s1_d.a_msb  = a[WIDTH-1];
        s1_d.be_msb = be[WIDTH-1];
        s1_d.sat    = sat_in;
    end

    // Stage-1 register: loads whenever it is empty or stage 2 will take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1_q <= '0;
        end else if (rdy1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    logic [NGRP:0]    gc;
    logic             acc;

    // Each group carry is its own two-level expression of c0, GG and GP,
    // so no group waits on the previous group's resolved carry.
    always_comb begin
        gc    = '0;
        acc   = 1'b0;
        gc[0] = s1_q.c0;
        for (int k = 0; k < NGRP; k++) begin
            acc = s1_q.c0;
            for (int j = 0; j <= k; j++) begin
                acc = s1_q.gg[j] | (s1_q.gp[j] & acc);
            end
            gc[k+1] = acc;
        end
    end

    logic [WIDTH-1:0] carry;
    logic [NGRP-1:0]  unused_gg;
    logic [NGRP-1:0]  unused_gp;
    logic [NGRP-1:0]  unused_c4;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        logic [4:1] c;

        cla_group4 u_grp (
            .g    (s1_q.g[k*CLA_GRP +: CLA_GRP]),
            .p    (s1_q.p[k*CLA_GRP +: CLA_GRP]),
            .cgrp (gc[k]),
            .c    (c),
            .gg   (unused_gg[k]),
            .gp   (unused_gp[k])
        );

        assign carry[k*CLA_GRP +: CLA_GRP] = {c[3:1], gc[k]};
        // Carry out of the group is already available as gc[k+1].
        assign unused_c4[k] = c[4];
    end

    logic unused_s1;
    assign unused_s1 = ^{s1_q, unused_gg, unused_gp, unused_c4};

    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] res_sum;
    logic             res_ovf;
    logic             res_zero;

    assign raw_sum = s1_q.x[WIDTH-1:0] ^ carry;
    assign res_ovf = (s1_q.a_msb == s1_q.be_msb) && (raw_sum[WIDTH-1] != s1_q.a_msb);

`ifdef CLA_SAT_EN
    // Clamp toward the sign of a; ovf stays set to report the clamp.
    always_comb begin
        res_sum = raw_sum;
        if (s1_q.sat && res_ovf) begin
            res_sum = s1_q.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res_sum = raw_sum;
`endif

    assign res_zero = (res_sum == '0);

    // Stage-2 register: holds the result while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) begin
                sum  <= res_sum;
                cout <= gc[NGRP];
                ovf  <= res_ovf;
                zero <= res_zero;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed vectors on a 32-bit
// instance (latency, flags, backpressure, reset), plus streamed beats with
// random handshakes on 4-bit and 64-bit instances against an a+b model.
// Honours CLA_SAT_EN when defined.
module tb_cla_pipe_adder;

    logic        clk;
    logic        rst_n;
    logic        iv;
    logic        ir;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        sat;
    logic        ov;
    logic        ordy;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int n_chk = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(32)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv),
        .in_ready  (ir),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
`ifdef CLA_SAT_EN
        .sat       (sat),
`endif
        .out_valid (ov),
        .out_ready (ordy),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated beat: accept, measure latency, check result and flags.
    task automatic beat(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic vcin, input logic vsub, input logic vsat,
                        input logic [31:0] esum, input logic ecout, input logic eovf,
                        input logic ezero);
        int lat;
        @(negedge clk);
        iv = 1'b1; a = va; b = vb; cin = vcin; sub = vsub; sat = vsat; ordy = 1'b1;
        #1;
        chk({tag, "_rdy"}, 64'(ir), 64'd1);
        @(negedge clk);
        iv  = 1'b0;
        lat = 1;
        while (!ov && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"},  64'(lat),  64'd2);
        chk({tag, "_sum"},  64'(sum),  64'(esum));
        chk({tag, "_cout"}, 64'(cout), 64'(ecout));
        chk({tag, "_ovf"},  64'(ovf),  64'(eovf));
        chk({tag, "_zero"}, 64'(zero), 64'(ezero));
    endtask

    // Streamed random beats on narrow and wide instances.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rand
        localparam int W = (gi == 0) ? 4 : 64;

        logic           rst_r;
        logic           riv;
        logic           rir;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic           rcin;
        logic           rsub;
        logic           rsat;
        logic           rov;
        logic           rordy;
        logic [W-1:0]   rsum;
        logic           rcout;
        logic           rovf;
        logic           rzero;
        logic           done;
        logic [W-1:0]   mbe;
        logic [W:0]     mfull;
        logic [W-1:0]   msum;
        logic           movf;
        logic [W+1:0]   ent;
        logic [W+1:0]   q[$];

        cla_pipe_adder #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_r),
            .in_valid  (riv),
            .in_ready  (rir),
            .a         (ra),
            .b         (rb),
            .cin       (rcin),
            .sub       (rsub),
`ifdef CLA_SAT_EN
            .sat       (rsat),
`endif
            .out_valid (rov),
            .out_ready (rordy),
            .sum       (rsum),
            .cout      (rcout),
            .ovf       (rovf),
            .zero      (rzero)
        );

        initial begin
            done = 1'b0; rst_r = 1'b0; riv = 1'b0; rordy = 1'b0;
            ra = '0; rb = '0; rcin = 1'b0; rsub = 1'b0; rsat = 1'b0;
            #23 rst_r = 1'b1;
            for (int k = 0; k < 4006; k++) begin
                @(negedge clk);
                if (k < 4000) begin
                    riv   = 1'($urandom_range(0, 1));
                    rordy = ($urandom_range(0, 3) != 0);
                end else begin
                    riv   = 1'b0;
                    rordy = 1'b1;
                end
                ra   = ($urandom_range(0, 7) == 0) ? '1 : W'({$urandom(), $urandom()});
                rb   = ($urandom_range(0, 7) == 0) ? '0 : W'({$urandom(), $urandom()});
                rcin = 1'($urandom_range(0, 1));
                rsub = 1'($urandom_range(0, 1));
                rsat = 1'($urandom_range(0, 1));
                #1;
                if (rov && rordy) begin
                    if (q.size() == 0) begin
                        chk(gi == 0 ? "r4_extra" : "r64_extra", 64'd1, 64'd0);
                    end else begin
                        ent = q.pop_front();
                        chk(gi == 0 ? "r4_sum" : "r64_sum",   64'(rsum),  64'(ent[W-1:0]));
                        chk(gi == 0 ? "r4_cout" : "r64_cout", 64'(rcout), 64'(ent[W]));
                        chk(gi == 0 ? "r4_ovf" : "r64_ovf",   64'(rovf),  64'(ent[W+1]));
                        chk(gi == 0 ? "r4_zero" : "r64_zero", 64'(rzero), 64'(ent[W-1:0] == '0));
                    end
                end
                if (riv && rir) begin
                    mbe   = rsub ? ~rb : rb;
                    mfull = {1'b0, ra} + {1'b0, mbe} + (W+1)'(rsub | rcin);
                    msum  = mfull[W-1:0];
                    movf  = (ra[W-1] == mbe[W-1]) && (msum[W-1] != ra[W-1]);
`ifdef CLA_SAT_EN
                    if (rsat && movf) begin
                        msum = ra[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                    end
`endif
                    q.push_back({movf, mfull[W], msum});
                end
            end
            chk(gi == 0 ? "r4_drain" : "r64_drain", 64'(q.size()), 64'd0);
            done = 1'b1;
        end
    end

    logic [31:0] exq[$];
    logic [31:0] held;
    int          idx;
    int          nout;

    initial begin
        rst_n = 1'b0; iv = 1'b0; ordy = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
        #3;
        chk("rst_ov",   64'(ov),   64'd0);
        chk("rst_sum",  64'(sum),  64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf",  64'(ovf),  64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        #19 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 64'(ir), 64'd1);

        beat("t1",     32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1);
        beat("t2a",    32'd5,         32'd7,         1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        beat("t2b",    32'h8000_0000, 32'h1,         1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        beat("t3",     32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        beat("cin",    32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
        beat("subeq",  32'h1234,      32'h1234,      1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1);
        beat("subcin", 32'd10,        32'd3,         1'b0, 1'b1, 1'b0, 32'd7,         1'b1, 1'b0, 1'b0);
        beat("grp",    32'h0FFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 32'h1000_0000, 1'b0, 1'b0, 1'b0);
        beat("wrap16", 32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1);
        beat("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1);
`ifdef CLA_SAT_EN
        beat("satpos", 32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        beat("satneg", 32'h8000_0000, 32'h1,         1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
        beat("satoff", 32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`endif

        // Eight back-to-back beats with out_ready low for cycles 3..6.
        idx  = 0;
        nout = 0;
        held = '0;
        for (int k = 0; k < 40 && (idx < 8 || exq.size() > 0); k++) begin
            @(negedge clk);
            ordy = !(k >= 3 && k <= 6);
            iv   = (idx < 8);
            a    = 32'h1000 * 32'(idx) + 32'd1;
            b    = 32'(idx);
            cin  = 1'b0; sub = 1'b0; sat = 1'b0;
            #1;
            if (k <= 2) chk("bp_rdy_hi", 64'(ir), 64'd1);
            else if (k <= 6) chk("bp_rdy_lo", 64'(ir), 64'd0);
            if (k == 3) held = sum;
            if (k >= 4 && k <= 6) chk("bp_hold", 64'(sum), 64'(held));
            if (ov && ordy) begin
                if (exq.size() == 0) begin
                    chk("bp_extra", 64'd1, 64'd0);
                end else begin
                    chk("bp_order", 64'(sum), 64'(exq.pop_front()));
                    nout++;
                end
            end
            if (iv && ir) begin
                exq.push_back(a + b);
                idx++;
            end
        end
        iv = 1'b0;
        chk("bp_sent",  64'(idx),  64'd8);
        chk("bp_count", 64'(nout), 64'd8);

        // Reset with two beats in flight.
        @(negedge clk);
        ordy = 1'b0; iv = 1'b1; a = 32'h55; b = 32'h22; sub = 1'b0; cin = 1'b0;
        @(negedge clk);
        a = 32'h66; b = 32'h11;
        @(negedge clk);
        iv = 1'b0;
        #1;
        chk("rr_pre_ov",  64'(ov),  64'd1);
        chk("rr_pre_sum", 64'(sum), 64'h77);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_ov",  64'(ov),  64'd0);
        chk("rr_sum", 64'(sum), 64'd0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        ordy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_no_out", 64'(ov), 64'd0);
        end
        chk("rr_rdy", 64'(ir), 64'd1);

        for (int t = 0; t < 6000 && !(g_rand[0].done && g_rand[1].done); t++) begin
            @(negedge clk);
        end
        chk("r4_done",  64'(g_rand[0].done), 64'd1);
        chk("r64_done", 64'(g_rand[1].done), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
